// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: drain FSM encoding for the output-memory reader.
// The names are chosen so they do not collide with the controller's STATE typedef.
package cnn_pkg;

    typedef enum logic [1:0] {
        D_COLLECT = 2'd0,
        D_FETCH   = 2'd1,
        D_SEND    = 2'd2,
        D_DONE    = 2'd3
    } drain_state_t;

endpackage

// File: rtl/outmem_ram.sv
// Output buffer storage: DEPTH x DATA_WIDTH, one write port, one registered read port.
// The storage array is not reset. Only the read-data register is reset, so out_data is 0 after reset.
module outmem_ram #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // read register: updated only on rd_en, so it holds steady while the word is being offered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/outmem_reader.sv
// Output-memory consumer: collects controller writes, then drains the buffer in address order
// to the host over valid/ready when the conv pulse arrives.
module outmem_reader
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] outmem_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  conv,
    input  logic [ADDR_WIDTH-1:0] num_results,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  wr_err
);

    // one extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_WIDTH
    localparam int CW     = ADDR_WIDTH + 1;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         drain_cnt_q, drain_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  drain_done_q, drain_done_d;
    logic                  busy_q;
    logic                  wr_err_q, wr_err_d;

    logic                  ram_wr_en_s;
    logic                  ram_rd_en_s;
    logic                  addr_in_range_s;
    logic [CW-1:0]         clamped_cnt_s;

    assign addr_in_range_s = ({1'b0, outmem_addr} < DEPTH_C);
    assign clamped_cnt_s   = ({1'b0, num_results} > DEPTH_C) ? DEPTH_C : {1'b0, num_results};

    // next-state, pointer and handshake logic
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        drain_cnt_d  = drain_cnt_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        drain_done_d = 1'b0;
        wr_err_d     = wr_err_q;
        ram_wr_en_s  = 1'b0;
        ram_rd_en_s  = 1'b0;

        if (write_enable) begin
            if ((state_q == D_COLLECT) && addr_in_range_s) begin
                ram_wr_en_s = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end else begin
            ram_wr_en_s = 1'b0;
        end

        case (state_q)
            D_COLLECT: begin
                if (conv) begin
                    drain_cnt_d = clamped_cnt_s;
                    rd_ptr_d    = {ADDR_WIDTH{1'b0}};
                    if (clamped_cnt_s == {CW{1'b0}}) begin
                        state_d      = D_DONE;
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = D_FETCH;
                    end
                end else begin
                    state_d = D_COLLECT;
                end
            end
            D_FETCH: begin
                ram_rd_en_s = 1'b1;
                out_index_d = rd_ptr_q;
                out_last_d  = (({1'b0, rd_ptr_q} + CW'(1)) == drain_cnt_q);
                out_valid_d = 1'b1;
                state_d     = D_SEND;
            end
            D_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d      = D_DONE;
                        drain_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                        state_d  = D_FETCH;
                    end
                end else begin
                    state_d = D_SEND;
                end
            end
            D_DONE: begin
                rd_ptr_d = {ADDR_WIDTH{1'b0}};
                state_d  = D_COLLECT;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = D_COLLECT;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= D_COLLECT;
            rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
            drain_cnt_q  <= {CW{1'b0}};
            out_valid_q  <= 1'b0;
            out_index_q  <= {ADDR_WIDTH{1'b0}};
            out_last_q   <= 1'b0;
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            drain_cnt_q  <= drain_cnt_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            drain_done_q <= drain_done_d;
            busy_q       <= (state_d != D_COLLECT);
            wr_err_q     <= wr_err_d;
        end
    end

    outmem_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_wr_en_s),
        .wr_addr (outmem_addr[RAM_AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en_s),
        .rd_addr (rd_ptr_q[RAM_AW-1:0]),
        .rd_data (out_data)
    );

    assign out_valid  = out_valid_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_outmem_reader.sv
// Directed bench for outmem_reader: a buffer model and an expected-beat queue,
// checked every cycle, plus literal expectations on timing and data.
module tb_outmem_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [9:0]  outmem_addr = 10'd0;
    logic [15:0] wr_data = 16'd0;
    logic        conv = 1'b0;
    logic [9:0]  num_results = 10'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [9:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        drain_done;
    logic        wr_err;

    outmem_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .outmem_addr  (outmem_addr),
        .wr_data      (wr_data),
        .conv         (conv),
        .num_results  (num_results),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .drain_done   (drain_done),
        .wr_err       (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] model_mem [64];
    logic        exp_wr_err = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats = 0;
    int          first_valid_cyc = -1;
    int          last_hs_cyc = -1;
    int          done_cyc = -1;
    bit          done_seen = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] obs_data [128];
    logic [9:0]  obs_index [128];
    logic        obs_last [128];

    task automatic check(input bit ok, input string name, input longint got, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // cycle-by-cycle comparison against the expected-beat queue and the sticky error model
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_done = 1'b0;
        end else begin
            check(wr_err === exp_wr_err, "wr_err", wr_err, exp_wr_err);
            if (drain_done) begin
                check(!prev_done, "drain_done_width", 1, 0);
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            prev_done = drain_done;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check(busy === 1'b1, "busy_during_valid", busy, 1);
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_valid", out_index, 0);
                end else begin
                    check(out_data  === exp_q[0].data, "beat_data",  out_data,  exp_q[0].data);
                    check(out_index === exp_q[0].idx,  "beat_index", out_index, exp_q[0].idx);
                    check(out_last  === exp_q[0].last, "beat_last",  out_last,  exp_q[0].last);
                    if (out_ready) begin
                        if (beats < 128) begin
                            obs_data[beats]  = out_data;
                            obs_index[beats] = out_index;
                            obs_last[beats]  = out_last;
                        end
                        beats++;
                        last_hs_cyc = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic write_word(input logic [9:0] a, input logic [15:0] d, input bit ok);
        write_enable = 1'b1;
        outmem_addr  = a;
        wr_data      = d;
        @(posedge clk); #1;
        write_enable = 1'b0;
        if (ok) model_mem[a[5:0]] = d;
        else exp_wr_err = 1'b1;
    endtask

    task automatic start_drain(input int num, output int t);
        int n;
        n = (num > 64) ? 64 : num;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{idx: 10'(i), data: model_mem[i], last: (i == n - 1)});
        end
        done_seen = 1'b0; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; beats = 0;
        conv = 1'b1;
        num_results = 10'(num);
        t = cyc;
        @(posedge clk); #1;
        conv = 1'b0;
        check(busy === 1'b1, "busy_after_conv", busy, 1);
    endtask

    // conv with num words; ready low for stall_len cycles from offset stall_off; optional write at wr_off
    task automatic drain(input int num, input int stall_off, input int stall_len,
                         input int wr_off, input logic [9:0] wa, input logic [15:0] wd);
        int  t;
        int  n;
        bit  wr_now;
        n = (num > 64) ? 64 : num;
        start_drain(num, t);
        while (!done_seen && (cyc - t) < 300) begin
            out_ready = !(((cyc - t) >= stall_off) && ((cyc - t) < stall_off + stall_len));
            wr_now = ((cyc - t) == wr_off);
            write_enable = wr_now;
            outmem_addr  = wa;
            wr_data      = wd;
            @(posedge clk); #1;
            write_enable = 1'b0;
            if (wr_now) exp_wr_err = 1'b1;
        end
        check(done_seen, "drain_timeout", done_seen, 1);
        check(beats == n, "beat_count", beats, n);
        check(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
        if (n > 0) begin
            check(first_valid_cyc == t + 2, "first_valid_latency", first_valid_cyc - t, 2);
            check(done_cyc == last_hs_cyc + 1, "done_after_last", done_cyc - last_hs_cyc, 1);
        end else begin
            check(first_valid_cyc < 0, "no_valid_on_zero", first_valid_cyc, -1);
            check(done_cyc == t + 1, "zero_done_latency", done_cyc - t, 1);
        end
        check(busy === 1'b0, "busy_after_done", busy, 0);
        check(drain_done === 1'b0, "done_dropped", drain_done, 0);
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1;
        check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        check(busy === 1'b0, "rst_busy", busy, 0);
        check(drain_done === 1'b0, "rst_drain_done", drain_done, 0);
        check(wr_err === 1'b0, "rst_wr_err", wr_err, 0);
        check(out_last === 1'b0, "rst_out_last", out_last, 0);
        check(out_index === 10'd0, "rst_out_index", out_index, 0);
        check(out_data === 16'd0, "rst_out_data", out_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) write_word(10'(i), 16'hA000 + 16'(i), 1'b1);

        // 1: four words, ready always high
        write_word(10'd0, 16'h0011, 1'b1);
        write_word(10'd1, 16'h0022, 1'b1);
        write_word(10'd2, 16'h0033, 1'b1);
        write_word(10'd3, 16'h0044, 1'b1);
        drain(4, -1, 0, -1, 10'd0, 16'd0);
        check(obs_data[0] === 16'h0011, "t1_data0", obs_data[0], 16'h0011);
        check(obs_data[3] === 16'h0044, "t1_data3", obs_data[3], 16'h0044);
        check(obs_index[3] === 10'd3, "t1_index3", obs_index[3], 3);
        check(obs_last[3] === 1'b1 && obs_last[2] === 1'b0, "t1_last", obs_last[3], 1);

        // 2: beat 2 first offered at t+6, held for 5 stalled cycles
        drain(4, 6, 5, -1, 10'd0, 16'd0);
        check(obs_data[2] === 16'h0033, "t2_data2", obs_data[2], 16'h0033);
        check(obs_index[2] === 10'd2, "t2_index2", obs_index[2], 2);

        // 3: empty drain
        drain(0, -1, 0, -1, 10'd0, 16'd0);

        // 4: out-of-range write, then a write dropped during SEND
        write_word(10'd64, 16'hDEAD, 1'b0);
        check(wr_err === 1'b1, "t4_wr_err", wr_err, 1);
        drain(8, -1, 0, 2, 10'd5, 16'hBEEF);
        drain(8, -1, 0, -1, 10'd0, 16'd0);
        check(obs_data[5] === 16'hA005, "t4_mem5_kept", obs_data[5], 16'hA005);
        check(obs_data[0] === 16'h0011, "t4_mem0_kept", obs_data[0], 16'h0011);

        // 5: request clamps to DEPTH
        drain(100, -1, 0, -1, 10'd0, 16'd0);
        check(obs_index[63] === 10'd63, "t5_index63", obs_index[63], 63);
        check(obs_last[63] === 1'b1, "t5_last63", obs_last[63], 1);

        // 6: reset while beat 1 is being offered
        start_drain(4, t);
        out_ready = 1'b1;
        while ((cyc - t) < 4) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check(out_valid === 1'b1, "t6_valid_beat1", out_valid, 1);
        check(out_index === 10'd1, "t6_index_beat1", out_index, 1);
        #1 reset = 1'b1;
        #1;
        check(out_valid === 1'b0, "t6_async_valid", out_valid, 0);
        check(busy === 1'b0, "t6_async_busy", busy, 0);
        exp_wr_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check(drain_done === 1'b0, "t6_no_done", drain_done, 0);
            check(busy === 1'b0, "t6_idle", busy, 0);
            @(posedge clk); #1;
        end
        drain(4, -1, 0, -1, 10'd0, 16'd0);
        check(obs_index[0] === 10'd0, "t6_restart_index", obs_index[0], 0);
        check(obs_data[1] === 16'h0022, "t6_restart_data1", obs_data[1], 16'h0022);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
